// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel rate.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter plus registered active/sync flags.
// The flags are loaded from the decode of the next position, so they line
// up with pos in the same cycle.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         at_end,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // Reject degenerate or overflowing timing at elaboration.
    if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0 || TOTAL > (1 << W)) begin : g_bad_cfg
        $error("vga_axis_counter: zero-length interval or total %0d exceeds 2**%0d", TOTAL, W);
    end

    logic [W-1:0] pos_reg, pos_next;
    logic         active_reg, active_next;
    logic         sync_reg, sync_next;
    int           pos_int;

    assign at_end = (pos_reg == LAST);

    // Advance/wrap the counter and decode flags for the upcoming position.
    always_comb begin
        pos_next = pos_reg;
        if (step) begin
            pos_next = at_end ? '0 : pos_reg + W'(1);
        end
        pos_int     = int'(pos_next);
        active_next = (pos_int < ACTIVE);
        sync_next   = ((pos_int >= ACTIVE + FP) && (pos_int < ACTIVE + FP + SYNC)) ? POL : ~POL;
    end

    // State registers; reset value is the decode of position 0.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pos_reg    <= '0;
            active_reg <= 1'b1;
            sync_reg   <= ~POL;
        end else begin
            pos_reg    <= pos_next;
            active_reg <= active_next;
            sync_reg   <= sync_next;
        end
    end

    assign pos    = pos_reg;
    assign active = active_reg;
    assign sync   = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = SYNC_ACT_LOW,
    parameter bit V_SYNC_POL = SYNC_ACT_LOW,
    parameter int HW         = 10,
    parameter int VW         = 10
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          pix_en,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hactive,
    output logic          vactive,
    output logic          active,
    output logic          line_pulse,
    output logic          frame_pulse,
    output logic          vblank_pulse
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_count
`endif
);

    localparam logic [VW-1:0] V_LAST_VISIBLE = VW'(V_ACTIVE - 1);

    logic h_at_end;
    logic v_at_end;
    logic v_step;

    // The vertical axis advances once per completed line.
    assign v_step = pix_en & h_at_end;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL),
        .W      (HW)
    ) u_h_axis (
        .clk    (clk),
        .nRst   (nRst),
        .step   (pix_en),
        .pos    (hpos),
        .at_end (h_at_end),
        .active (hactive),
        .sync   (hsync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL),
        .W      (VW)
    ) u_v_axis (
        .clk    (clk),
        .nRst   (nRst),
        .step   (v_step),
        .pos    (vpos),
        .at_end (v_at_end),
        .active (vactive),
        .sync   (vsync)
    );

    assign active       = hactive & vactive;
    assign line_pulse   = v_step;
    assign frame_pulse  = v_step & v_at_end;
    assign vblank_pulse = v_step & (vpos == V_LAST_VISIBLE);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_count_reg;

    // Free-running frame counter for blink/animation, wraps naturally.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            frame_count_reg <= 8'd0;
        end else if (frame_pulse) begin
            frame_count_reg <= frame_count_reg + 8'd1;
        end
    end

    assign frame_count = frame_count_reg;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Next generation of the fixed 640x480 timing block: porch, sync and active lengths, sync polarity and counter widths are parameters, and a pixel clock-enable allows a fast system clock. Feeds pixel generators, the frame buffer reader and the video DAC/pin mux. Adds a vblank-start pulse and zero-skew registered sync and active outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, 0 = hsync active-low, 1 = active-high
V_SYNC_POL, 0, 0 = vsync active-low, 1 = active-high
HW, 10, hpos width; H_TOTAL (sum of H_* lengths) must be <= 2^HW
VW, 10, vpos width; V_TOTAL (sum of V_* lengths) must be <= 2^VW

Ports:
clk  in  1  clock
nRst  in  1  reset, asynchronous, active-low
pix_en  in  1  pixel clock-enable; all timing advances only on clk edges with pix_en=1
hpos  out  HW  current horizontal position, 0..H_TOTAL-1
vpos  out  VW  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
hactive  out  1  hpos < H_ACTIVE
vactive  out  1  vpos < V_ACTIVE
active  out  1  hactive & vactive
line_pulse  out  1  last pixel of line
frame_pulse  out  1  last pixel of frame
vblank_pulse  out  1  last pixel of last visible line

Behaviour:
- Reset (async, immediate): hpos=0, vpos=0, hactive=1, vactive=1, active=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, all pulses 0.
- Horizontal counter: on pix_en, hpos increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments when pix_en and hpos==H_TOTAL-1; wraps to 0 from V_TOTAL-1 on that same event.
- hsync, vsync, hactive and vactive are registers. Each is loaded from the decode of the next counter value, so it is aligned with hpos/vpos in the same cycle (zero skew):
  - hsync asserted iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- active is combinational: hactive & vactive.
- line_pulse = pix_en & (hpos==H_TOTAL-1), combinational, exactly one clk wide.
- frame_pulse = line_pulse & (vpos==V_TOTAL-1).
- vblank_pulse = line_pulse & (vpos==V_ACTIVE-1).
- pix_en=0: every register holds and all pulses are 0.
- Latency: a position and its decoded flags are valid in the same cycle; no pipeline offset.
- Elaboration: H_TOTAL > 2^HW, V_TOTAL > 2^VW, or any length of 0 triggers $error.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output frame_count [7:0]. Resets to 0, increments on frame_pulse, wraps 255 -> 0. Used for blink and animation.
- Undefined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package vga_timing_pkg: default 640x480@60 constants (H_*/V_*), derived H_TOTAL/V_TOTAL localparams, sync polarity constants SYNC_ACT_LOW/SYNC_ACT_HIGH.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical).
  - Params: ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: step enable.
  - Outputs: pos, at_end, active, sync.
  - Top level supplies step = pix_en (horizontal) and step = line advance (vertical), and forms the pulses.

Test Plan:
1. Defaults, pix_en=1 after reset -> hpos runs 0..799 and wraps; line_pulse high only at hpos=799, period 800 clk; vpos wraps 524 -> 0.
2. Defaults -> hsync low exactly at hpos 656..751 (96 clk); hactive=1 at hpos 0..639 and 0 at 640..799; active=0 whenever vpos >= 480.
3. Defaults -> vsync low for whole lines 490-491; frame_pulse at (799,524), period 420000 clk; vblank_pulse at (799,479) once per frame.
4. pix_en toggling 1/0 every clk -> frame period 840000 clk; pulses one clk wide and only on pix_en=1 cycles; all outputs stable across pix_en=0 cycles.
5. Params H 8/2/2/2, V 4/1/1/1, H_SYNC_POL=1 -> hsync high at hpos 10..11; vsync low at vpos 5; frame period 14*7 = 98 clk.
6. nRst low at hpos=300, vpos=100 -> outputs take reset values with no clk edge; after release, count restarts from (0,0). With VGA_TIMING_FRAME_CNT_EN: frame_count 255 -> 0 on frame_pulse.
